// File: rtl/rng_stats_pkg.sv
// Shared types and constants for the random-bit word statistics engine.
// Statistic fields are sized for the default 256-bit word (counts up to 256).
package rng_stats_pkg;

  localparam int unsigned DEF_WORD_SIZE = 256;
  localparam int unsigned DEF_CW        = $clog2(DEF_WORD_SIZE) + 1;
  localparam int unsigned STAT_W        = DEF_CW;
  localparam int unsigned FAIL_W        = 16;

  typedef logic [STAT_W-1:0] stat_t;

  typedef struct packed {
    stat_t popcount;
    stat_t trans;
    logic  lead_val;
    stat_t lead_len;
    stat_t trail_len;
    stat_t max1;
    stat_t max0;
  } beat_stats_t;

  typedef struct packed {
    stat_t ones;
    stat_t trans;
    stat_t max1;
    stat_t max0;
  } word_stats_t;

  function automatic stat_t max2(stat_t a, stat_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rng_word_stats_if.sv
// Beat input, band configuration and per-word result bundle of rng_word_stats.
interface rng_word_stats_if
  import rng_stats_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 256,
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned CW        = $clog2(WORD_SIZE) + 1
);

  logic                 clear;
  logic                 in_valid;
  logic [IN_WIDTH-1:0]  in_data;
  logic [CW-1:0]        ones_lo;
  logic [CW-1:0]        ones_hi;

  logic                 out_valid;
  logic [WORD_SIZE-1:0] out_word;
  logic [CW-1:0]        ones;
  logic [CW-1:0]        change_sign_count;
  logic [CW-1:0]        ones_max_len;
  logic [CW-1:0]        zeros_max_len;
  logic                 out_fail;
  logic [FAIL_W-1:0]    fail_count;

  modport master (
    output clear, in_valid, in_data, ones_lo, ones_hi,
    input  out_valid, out_word, ones, change_sign_count, ones_max_len, zeros_max_len,
           out_fail, fail_count
  );

  modport slave (
    input  clear, in_valid, in_data, ones_lo, ones_hi,
    output out_valid, out_word, ones, change_sign_count, ones_max_len, zeros_max_len,
           out_fail, fail_count
  );

endinterface

// File: rtl/beat_run_stats.sv
// Combinational reduction of one beat into popcount, transitions and run lengths.
// Bit 0 is the earliest bit; the trailing run is the one ending at the MSB.
module beat_run_stats
  import rng_stats_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 8
) (
  input  logic [IN_WIDTH-1:0] beat,
  output beat_stats_t         stats
);

  stat_t run;
  logic  in_lead;

  always_comb begin
    stats          = '0;
    run            = STAT_W'(1);
    in_lead        = 1'b1;
    stats.lead_val = beat[0];
    stats.popcount = STAT_W'(beat[0]);
    stats.lead_len = STAT_W'(1);
    stats.max1     = STAT_W'(beat[0]);
    stats.max0     = STAT_W'(!beat[0]);
    for (int i = 1; i < IN_WIDTH; i++) begin
      stats.popcount = stats.popcount + STAT_W'(beat[i]);
      if (beat[i] != beat[i-1]) begin
        stats.trans = stats.trans + STAT_W'(1);
        run         = STAT_W'(1);
        in_lead     = 1'b0;
      end else begin
        run = run + STAT_W'(1);
      end
      if (in_lead) begin
        stats.lead_len = stats.lead_len + STAT_W'(1);
      end
      if (beat[i]) begin
        stats.max1 = max2(stats.max1, run);
      end else begin
        stats.max0 = max2(stats.max0, run);
      end
    end
    stats.trail_len = run;
  end

endmodule

// File: rtl/rng_word_stats.sv
// Streaming per-word statistics: beat reduction, incremental word accumulation,
// band / run-limit check and a saturating fail counter.
module rng_word_stats
  import rng_stats_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 256,
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned RUN_LIMIT = 32,
  parameter int unsigned CW        = $clog2(WORD_SIZE) + 1
) (
  input logic              clk,
  input logic              rst,
  rng_word_stats_if.slave  stats_bus
);

  localparam int unsigned BEATS = WORD_SIZE / IN_WIDTH;
  localparam int unsigned IDX_W = $clog2(BEATS);

  // Stage 1: registered beat reduction
  beat_stats_t         beat_stats;
  beat_stats_t         s1_stats_q;
  logic [IN_WIDTH-1:0] s1_beat_q;
  logic                s1_valid_q, s1_first_q, s1_last_q;
  logic [IDX_W-1:0]    idx_q;

  beat_run_stats #(
    .IN_WIDTH (IN_WIDTH)
  ) u_beat_run_stats (
    .beat  (stats_bus.in_data),
    .stats (beat_stats)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_stats_q <= '0;
      s1_beat_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      idx_q      <= '0;
    end else if (stats_bus.clear) begin
      s1_stats_q <= '0;
      s1_beat_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      idx_q      <= '0;
    end else begin
      s1_valid_q <= stats_bus.in_valid;
      if (stats_bus.in_valid) begin
        s1_stats_q <= beat_stats;
        s1_beat_q  <= stats_bus.in_data;
        s1_first_q <= (idx_q == '0);
        s1_last_q  <= (idx_q == IDX_W'(BEATS - 1));
        idx_q      <= idx_q + IDX_W'(1);
      end
    end
  end

  // Stage 2: word accumulator
  word_stats_t          acc_q, acc_d;
  logic                 cur_val_q, cur_val_d;
  stat_t                cur_len_q, cur_len_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic                 done_q;
  stat_t                cont;
  logic                 match, uniform;

  always_comb begin
    acc_d     = acc_q;
    cur_val_d = s1_beat_q[IN_WIDTH-1];
    cur_len_d = s1_stats_q.trail_len;
    shift_d   = {s1_beat_q, shift_q[WORD_SIZE-1:IN_WIDTH]};
    match     = (s1_stats_q.lead_val == cur_val_q);
    uniform   = (s1_stats_q.lead_len == STAT_W'(IN_WIDTH));
    cont      = match ? (cur_len_q + s1_stats_q.lead_len) : s1_stats_q.lead_len;
    if (s1_first_q) begin
      acc_d.ones  = s1_stats_q.popcount;
      acc_d.trans = s1_stats_q.trans;
      acc_d.max1  = s1_stats_q.max1;
      acc_d.max0  = s1_stats_q.max0;
    end else begin
      acc_d.ones  = acc_q.ones + s1_stats_q.popcount;
      acc_d.trans = acc_q.trans + s1_stats_q.trans + STAT_W'(!match);
      acc_d.max1  = max2(acc_q.max1, s1_stats_q.max1);
      acc_d.max0  = max2(acc_q.max0, s1_stats_q.max0);
      // The leading run may extend the run carried in from the previous beat
      if (s1_stats_q.lead_val) begin
        acc_d.max1 = max2(acc_d.max1, cont);
      end else begin
        acc_d.max0 = max2(acc_d.max0, cont);
      end
      if (uniform) begin
        cur_len_d = cont;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      cur_val_q <= 1'b0;
      cur_len_q <= '0;
      shift_q   <= '0;
      done_q    <= 1'b0;
    end else if (stats_bus.clear) begin
      acc_q     <= '0;
      cur_val_q <= 1'b0;
      cur_len_q <= '0;
      shift_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= s1_valid_q & s1_last_q;
      if (s1_valid_q) begin
        acc_q     <= acc_d;
        cur_val_q <= cur_val_d;
        cur_len_q <= cur_len_d;
        shift_q   <= shift_d;
      end
    end
  end

  // Output stage: unaffected by clear
  logic                 word_fail;
  logic                 out_valid_q, out_fail_q;
  logic [WORD_SIZE-1:0] out_word_q;
  stat_t                ones_q, trans_q, max1_q, max0_q;
  logic [FAIL_W-1:0]    fail_count_q;

  assign word_fail = (acc_q.ones < STAT_W'(stats_bus.ones_lo)) ||
                     (acc_q.ones > STAT_W'(stats_bus.ones_hi)) ||
                     (acc_q.max1 > STAT_W'(RUN_LIMIT)) ||
                     (acc_q.max0 > STAT_W'(RUN_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_fail_q   <= 1'b0;
      out_word_q   <= '0;
      ones_q       <= '0;
      trans_q      <= '0;
      max1_q       <= '0;
      max0_q       <= '0;
      fail_count_q <= '0;
    end else begin
      out_valid_q <= done_q;
      if (done_q) begin
        out_fail_q <= word_fail;
        out_word_q <= shift_q;
        ones_q     <= acc_q.ones;
        trans_q    <= acc_q.trans;
        max1_q     <= acc_q.max1;
        max0_q     <= acc_q.max0;
        if (word_fail && (fail_count_q != '1)) begin
          fail_count_q <= fail_count_q + FAIL_W'(1);
        end
      end
    end
  end

  assign stats_bus.out_valid         = out_valid_q;
  assign stats_bus.out_word          = out_word_q;
  assign stats_bus.ones              = CW'(ones_q);
  assign stats_bus.change_sign_count = CW'(trans_q);
  assign stats_bus.ones_max_len      = CW'(max1_q);
  assign stats_bus.zeros_max_len     = CW'(max0_q);
  assign stats_bus.out_fail          = out_fail_q;
  assign stats_bus.fail_count        = fail_count_q;

endmodule

// File: tb/tb_rng_word_stats.sv
// Directed bench for rng_word_stats with hand-computed expected word statistics.
module tb_rng_word_stats;

  localparam int unsigned WS    = 256;
  localparam int unsigned IW    = 8;
  localparam int unsigned CW    = 9;
  localparam int unsigned BEATS = WS / IW;

  logic          clk = 1'b0;
  logic          rst;
  int            n_checks = 0;
  int            n_errors = 0;
  int            pulses   = 0;
  int            lat;
  logic [IW-1:0] beats [BEATS];

  rng_word_stats_if #(.WORD_SIZE(WS), .IN_WIDTH(IW), .CW(CW)) sbus ();

  rng_word_stats #(
    .WORD_SIZE (WS),
    .IN_WIDTH  (IW),
    .RUN_LIMIT (32),
    .CW        (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stats_bus (sbus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (sbus.out_valid) pulses++;
  endtask

  task automatic send_beat(input logic [IW-1:0] d);
    sbus.in_valid = 1'b1;
    sbus.in_data  = d;
    tick();
    sbus.in_valid = 1'b0;
  endtask

  task automatic fill(input logic [IW-1:0] v);
    for (int k = 0; k < BEATS; k++) beats[k] = v;
  endtask

  task automatic send_word(input bit gaps);
    for (int k = 0; k < BEATS; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send_beat(beats[k]);
    end
  endtask

  // Cycles from the last accepted beat until out_valid is seen (0 = never)
  task automatic wait_result(input string tag, output int l);
    bit seen;
    seen = 1'b0;
    l    = 0;
    for (int c = 1; c <= 8; c++) begin
      if (!seen) begin
        tick();
        if (sbus.out_valid) begin
          seen = 1'b1;
          l    = c;
        end
      end
    end
    check_eq({tag, "_seen"}, 256'(seen), 256'(1));
  endtask

  task automatic check_stats(input string tag, input int o, input int t, input int m1,
                             input int m0, input int f, input int fc);
    check_eq({tag, "_ones"},  256'(sbus.ones),              256'(o));
    check_eq({tag, "_trans"}, 256'(sbus.change_sign_count), 256'(t));
    check_eq({tag, "_max1"},  256'(sbus.ones_max_len),      256'(m1));
    check_eq({tag, "_max0"},  256'(sbus.zeros_max_len),     256'(m0));
    check_eq({tag, "_fail"},  256'(sbus.out_fail),          256'(f));
    check_eq({tag, "_fcnt"},  256'(sbus.fail_count),        256'(fc));
  endtask

  initial begin
    rst           = 1'b1;
    sbus.clear    = 1'b0;
    sbus.in_valid = 1'b0;
    sbus.in_data  = '0;
    sbus.ones_lo  = 9'd100;
    sbus.ones_hi  = 9'd200;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 256'(sbus.out_valid), 256'(0));
    check_eq("rst_word", sbus.out_word, 256'(0));
    check_stats("rst", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();

    // All ones: above band and run far over the limit
    fill(8'hFF);
    send_word(1'b0);
    wait_result("t1", lat);
    check_eq("t1_lat", 256'(lat), 256'(2));
    check_stats("t1", 256, 0, 256, 0, 1, 1);
    check_eq("t1_word", sbus.out_word, {256{1'b1}});
    tick();
    check_eq("t1_pulse", 256'(sbus.out_valid), 256'(0));
    check_eq("t1_hold", 256'(sbus.ones), 256'(256));

    // Alternating bits
    fill(8'h55);
    send_word(1'b0);
    wait_result("t2", lat);
    check_stats("t2", 128, 255, 1, 1, 0, 1);

    // Ones run crossing the beat boundary
    fill(8'h00);
    beats[0] = 8'hF0;
    beats[1] = 8'h0F;
    send_word(1'b0);
    wait_result("t3", lat);
    check_stats("t3", 8, 2, 8, 244, 1, 2);
    check_eq("t3_word", sbus.out_word, 256'h0ff0);

    // Same word with random gaps
    send_word(1'b1);
    wait_result("t4", lat);
    check_eq("t4_lat", 256'(lat), 256'(2));
    check_stats("t4", 8, 2, 8, 244, 1, 3);
    check_eq("t4_word", sbus.out_word, 256'h0ff0);

    // Partial word flushed by clear, colliding beat dropped
    pulses = 0;
    repeat (5) send_beat(8'hFF);
    sbus.clear    = 1'b1;
    sbus.in_valid = 1'b1;
    sbus.in_data  = 8'hFF;
    tick();
    sbus.clear    = 1'b0;
    sbus.in_valid = 1'b0;
    fill(8'hAA);
    send_word(1'b0);
    wait_result("t5", lat);
    check_stats("t5", 128, 255, 1, 1, 0, 3);
    repeat (4) tick();
    check_eq("t5_pulses", 256'(pulses), 256'(1));

    // Reset mid-word
    repeat (10) send_beat(8'hFF);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", 256'(sbus.out_valid), 256'(0));
    check_eq("t6_rst_word", sbus.out_word, 256'(0));
    check_stats("t6_rst", 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst    = 1'b0;
    pulses = 0;
    fill(8'h00);
    send_word(1'b0);
    wait_result("t6", lat);
    check_stats("t6", 0, 0, 0, 256, 1, 1);
    check_eq("t6_word", sbus.out_word, 256'(0));
    repeat (4) tick();
    check_eq("t6_pulses", 256'(pulses), 256'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
